nes_shift_sequencer: RTL
========================

// Module: nes_shift_sequencer
// PURPOSE
// Polls the NES pad over its latch/clock/data serial link and turns Right/Left presses into
// increase/decrease/register control for the display-offset shift counter.
// Sits between the pad pins and the counter; gives press-edge plus auto-repeat stepping and a
// register pulse timed so increase/decrease are stable around its rising edge.
// PARAMETERS
// CLK_DIV       4       clk cycles per half pad-clock period (>=1)
// POLL_CYCLES   100000  idle clk cycles between polls (>=1)
// REPEAT_DELAY  20      held-button polls before the first auto-repeat step (>=1)
// REPEAT_RATE   4       held-button polls between later auto-repeat steps (>=1)
// INC_BIT       7       buttons[] index driving increase (Right)
// DEC_BIT       6       buttons[] index driving decrease (Left)
// PORTS
// clk            in   1  system clock; all state changes on its rising edge
// reset          in   1  asynchronous, active-high reset
// pad_data       in   1  serial pad data, active-low (0 = pressed)
// pad_latch      out  1  pad latch/strobe
// pad_clk        out  1  pad shift clock
// buttons        out  8  last complete frame, 1 = pressed: [0]A [1]B [2]Sel [3]Start [4]Up [5]Dn [6]L [7]R
// buttons_valid  out  1  one-cycle pulse when buttons updates
// increase       out  1  to shift counter increase
// decrease       out  1  to shift counter decrease
// register       out  1  to shift counter register (its update edge)
// busy           out  1  high in every state except IDLE
// BEHAVIOUR
// Reset (async): state IDLE; all outputs 0; poll/phase/bit/repeat counters 0; prev_dir NONE.
//  Reset mid-frame aborts at once; partial frame discarded; buttons cleared.
// FSM: IDLE -> LATCH -> READ -> DECIDE -> (STEP_SETUP -> STEP_EDGE -> STEP_HOLD) -> IDLE.
// IDLE: poll counter counts each cycle; at POLL_CYCLES-1 -> LATCH, counter cleared.
// LATCH: pad_latch=1 for exactly 2*CLK_DIV cycles, pad_clk=0.
// READ, bit k=0..7: low half CLK_DIV cycles (pad_clk=0); on its last cycle shift_reg[k] <= ~pad_data.
//  For k<7 follow with high half CLK_DIV cycles (pad_clk=1). After bit 7 sample -> DECIDE.
//  Frame = 17*CLK_DIV cycles from LATCH entry to DECIDE entry. No pad_clk pulse after bit 7.
// DECIDE (1 cycle): buttons <= shift_reg; buttons_valid=1.
//  dir = INC if R&~L, DEC if L&~R, else NONE (both or neither pressed).
//  NONE: no step; repeat counter 0. dir != prev_dir (press edge or reversal): step; repeat <= REPEAT_DELAY.
//  dir == prev_dir != NONE: repeat decrements; if it reaches 0: step, repeat <= REPEAT_RATE.
//  prev_dir <= dir. Step -> STEP_SETUP, else -> IDLE.
// Step sequence, one cycle each:
//  STEP_SETUP: increase/decrease driven (exactly one high), register=0.
//  STEP_EDGE: register=1, increase/decrease unchanged.
//  STEP_HOLD: register=0, increase/decrease unchanged. Then both cleared, -> IDLE.
//  Result: exactly one register rising edge per step, with increase/decrease stable 1 cycle before and after it.
//  increase and decrease are never high together; register is never high outside STEP_EDGE.
// Poll counter is used only in IDLE, so the poll period is POLL_CYCLES + frame + DECIDE + step cycles.
// Counter widths: $clog2(max+1) for each count limit; no counter may wrap.
// TESTING (bench params: CLK_DIV=2 POLL_CYCLES=16 REPEAT_DELAY=3 REPEAT_RATE=1)
// 1 Reset: hold reset mid-READ -> pad_latch/pad_clk/register/increase/decrease/busy drop to 0 at once; first LATCH 16 cycles after release.
// 2 Frame timing: model returns 0x3C-pattern -> latch high 4 cycles, 7 pad_clk pulses each 2 high/2 low, buttons matches, buttons_valid one pulse 35 cycles after LATCH entry.
// 3 Tap Right one poll -> one register edge with increase=1, decrease=0; next poll released -> no edge.
// 4 Hold Left 8 polls -> steps at polls 1,4,5,6,7,8 (decrease only); counter model -6.
// 5 Hold Right+Left -> no register edge; release Left while Right held -> step on that poll (new edge).
// 6 Right held 3 polls then switched to Left -> reversal steps decrease at once; repeat restarts from REPEAT_DELAY.

Source files
------------

// File: rtl/nes_shift_sequencer.sv
// NES pad poller: latch/clock/data serial read, then Right/Left press-edge and auto-repeat
// stepping that drives increase/decrease/register of the display-offset shift counter.
module nes_shift_sequencer #(
    parameter int CLK_DIV      = 4,
    parameter int POLL_CYCLES  = 100000,
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 4,
    parameter int INC_BIT      = 7,
    parameter int DEC_BIT      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] buttons,
    output logic       buttons_valid,
    output logic       increase,
    output logic       decrease,
    output logic       register,
    output logic       busy
);

    localparam int POLL_W  = $clog2(POLL_CYCLES + 1);
    localparam int PH_W    = $clog2(2 * CLK_DIV + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_READ   = 3'd2,
        S_DECIDE = 3'd3,
        S_SETUP  = 3'd4,
        S_EDGE   = 3'd5,
        S_HOLD   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_INC  = 2'd1,
        DIR_DEC  = 2'd2
    } dir_t;

    state_t              r_state;
    logic [POLL_W-1:0]   r_poll_cnt;
    logic [PH_W-1:0]     r_phase_cnt;
    logic [2:0]          r_bit_cnt;
    logic                r_half;
    logic [7:0]          r_shift;
    logic [REP_W-1:0]    r_rep_cnt;
    dir_t                r_prev_dir;
    dir_t                r_step_dir;

    state_t              w_state_nxt;
    logic [POLL_W-1:0]   w_poll_nxt;
    logic [PH_W-1:0]     w_phase_nxt;
    logic [2:0]          w_bit_nxt;
    logic                w_half_nxt;
    logic [7:0]          w_shift_nxt;
    logic [REP_W-1:0]    w_rep_nxt;
    dir_t                w_prev_nxt;
    dir_t                w_step_nxt;
    dir_t                w_dir;
    logic                w_stepping;

    // Direction requested by the frame just read; both or neither pressed means no direction.
    always_comb begin
        w_dir = DIR_NONE;
        if (r_shift[INC_BIT] && !r_shift[DEC_BIT]) begin
            w_dir = DIR_INC;
        end else if (r_shift[DEC_BIT] && !r_shift[INC_BIT]) begin
            w_dir = DIR_DEC;
        end else begin
            w_dir = DIR_NONE;
        end
    end

    // Next-state and counter logic for the poll/read/step sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_poll_nxt  = r_poll_cnt;
        w_phase_nxt = r_phase_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_half_nxt  = r_half;
        w_shift_nxt = r_shift;
        w_rep_nxt   = r_rep_cnt;
        w_prev_nxt  = r_prev_dir;
        w_step_nxt  = r_step_dir;
        case (r_state)
            S_IDLE: begin
                if (r_poll_cnt == POLL_W'(POLL_CYCLES - 1)) begin
                    w_state_nxt = S_LATCH;
                    w_poll_nxt  = '0;
                    w_phase_nxt = '0;
                end else begin
                    w_poll_nxt = r_poll_cnt + POLL_W'(1);
                end
            end
            S_LATCH: begin
                if (r_phase_cnt == PH_W'(2 * CLK_DIV - 1)) begin
                    w_state_nxt = S_READ;
                    w_phase_nxt = '0;
                    w_half_nxt  = 1'b0;
                    w_bit_nxt   = 3'd0;
                end else begin
                    w_phase_nxt = r_phase_cnt + PH_W'(1);
                end
            end
            S_READ: begin
                if (r_phase_cnt == PH_W'(CLK_DIV - 1)) begin
                    w_phase_nxt = '0;
                    if (!r_half) begin
                        w_shift_nxt[r_bit_cnt] = ~pad_data;
                        // The last bit has no trailing high half: the pad sees no eighth clock.
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = S_DECIDE;
                        end else begin
                            w_half_nxt = 1'b1;
                        end
                    end else begin
                        w_half_nxt = 1'b0;
                        w_bit_nxt  = r_bit_cnt + 3'd1;
                    end
                end else begin
                    w_phase_nxt = r_phase_cnt + PH_W'(1);
                end
            end
            S_DECIDE: begin
                w_prev_nxt  = w_dir;
                w_state_nxt = S_IDLE;
                if (w_dir == DIR_NONE) begin
                    w_rep_nxt = '0;
                end else if (w_dir != r_prev_dir) begin
                    w_rep_nxt   = REP_W'(REPEAT_DELAY);
                    w_step_nxt  = w_dir;
                    w_state_nxt = S_SETUP;
                end else if (r_rep_cnt <= REP_W'(1)) begin
                    w_rep_nxt   = REP_W'(REPEAT_RATE);
                    w_step_nxt  = w_dir;
                    w_state_nxt = S_SETUP;
                end else begin
                    w_rep_nxt = r_rep_cnt - REP_W'(1);
                end
            end
            S_SETUP: begin
                w_state_nxt = S_EDGE;
            end
            S_EDGE: begin
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_stepping = (w_state_nxt == S_SETUP) || (w_state_nxt == S_EDGE) ||
                        (w_state_nxt == S_HOLD);

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_poll_cnt  <= '0;
            r_phase_cnt <= '0;
            r_bit_cnt   <= 3'd0;
            r_half      <= 1'b0;
            r_shift     <= 8'h00;
            r_rep_cnt   <= '0;
            r_prev_dir  <= DIR_NONE;
            r_step_dir  <= DIR_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_poll_cnt  <= w_poll_nxt;
            r_phase_cnt <= w_phase_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_half      <= w_half_nxt;
            r_shift     <= w_shift_nxt;
            r_rep_cnt   <= w_rep_nxt;
            r_prev_dir  <= w_prev_nxt;
            r_step_dir  <= w_step_nxt;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pad_latch     <= 1'b0;
            pad_clk       <= 1'b0;
            buttons       <= 8'h00;
            buttons_valid <= 1'b0;
            increase      <= 1'b0;
            decrease      <= 1'b0;
            register      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            pad_latch     <= (w_state_nxt == S_LATCH);
            pad_clk       <= (w_state_nxt == S_READ) && w_half_nxt;
            buttons_valid <= (r_state == S_DECIDE);
            increase      <= w_stepping && (w_step_nxt == DIR_INC);
            decrease      <= w_stepping && (w_step_nxt == DIR_DEC);
            register      <= (w_state_nxt == S_EDGE);
            busy          <= (w_state_nxt != S_IDLE);
            if (r_state == S_DECIDE) begin
                buttons <= r_shift;
            end else begin
                buttons <= buttons;
            end
        end
    end

endmodule
